// File: rtl/n64_cfg_mbox.sv
// n64_cfg_mbox: N64-visible configuration mailbox.
// Key-locked register file, a command/argument/result mailbox toward a local
// controller, sticky interrupt sources and a registered IRQ to the N64.
// Optional feature macro: CFG_TIMEOUT_EN adds a command timeout. A command
// then stays pending for at most TIMEOUT_CYCLES cycles. cmd_abort pulses in
// the first cycle after the command is dropped.
module n64_cfg_mbox #(
  parameter int DATA_WORDS     = 2,
  parameter int IRQ_SOURCES    = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_write,
  input  logic [16:0]               bus_address,
  input  logic [15:0]               bus_wdata,
  output logic [15:0]               bus_rdata,
  input  logic                      n64_reset,
  input  logic                      n64_nmi,
  output logic                      cmd_pending,
  output logic [7:0]                cmd_code,
  output logic [32*DATA_WORDS-1:0]  cmd_args,
  input  logic                      cmd_done,
  input  logic                      cmd_error,
  input  logic [32*DATA_WORDS-1:0]  cmd_result,
  output logic                      cmd_abort,
  input  logic [IRQ_SOURCES-1:0]    irq_src,
  output logic                      unlocked,
  output logic                      irq
);
  localparam logic [4:0]  R_STATUS  = 5'd0;
  localparam logic [4:0]  R_COMMAND = 5'd1;
  localparam logic [4:0]  R_KEY     = 5'd2;
  localparam logic [4:0]  R_PEND    = 5'd3;
  localparam logic [4:0]  R_EN      = 5'd4;
  localparam logic [15:0] LOCK_KEY  = 16'hFFFF;

  // Unlock sequence spells "_UNLOCK_" in ASCII.
  function automatic logic [15:0] unlock_key(input logic [1:0] s);
    case (s)
      2'd0:    return 16'h5F55;
      2'd1:    return 16'h4E4C;
      2'd2:    return 16'h4F43;
      default: return 16'h4B5F;
    endcase
  endfunction

  logic                         pending_q, pending_d;
  logic [7:0]                   code_q, code_d;
  logic                         irqreq_q, irqreq_d;
  logic                         err_q, err_d;
  logic                         timeout_q, timeout_d;
  logic                         cmd_irq_q, cmd_irq_d;
  logic                         unlocked_q, unlocked_d;
  logic [IRQ_SOURCES-1:0]       pend_q, pend_d;
  logic [IRQ_SOURCES-1:0]       en_q, en_d;
  logic [DATA_WORDS-1:0][31:0]  data_q, data_d;
  logic [1:0]                   ukey_q, ukey_d;
  logic                         lkey_q, lkey_d;
  logic                         irq_q;
  logic                         to_fire;

  // Address decode: block window at [16]=1, [15:6]=0; halfword register index.
  logic       sel, wr, dsel;
  logic [4:0] idx, doff;
  assign sel  = bus_address[16] && (bus_address[15:6] == 10'd0);
  assign idx  = bus_address[5:1];
  assign wr   = bus_write && sel;
  assign doff = idx - 5'd8;
  assign dsel = (idx >= 5'd8) && (idx < 5'(8 + 2*DATA_WORDS));

  // Combinational read mux; zero when the block is not addressed.
  always_comb begin
    bus_rdata = '0;
    if (sel) begin
      case (idx)
        R_STATUS:  bus_rdata = {pending_q, err_q, cmd_irq_q, timeout_q, unlocked_q, 11'd0};
        R_COMMAND: bus_rdata = {7'd0, irqreq_q, code_q};
        R_PEND:    bus_rdata = 16'(pend_q);
        R_EN:      bus_rdata = 16'(en_q);
        default: begin
          for (int k = 0; k < DATA_WORDS; k++)
            if (dsel && doff[3:1] == 3'(k))
              bus_rdata = doff[0] ? data_q[k][15:0] : data_q[k][31:16];
        end
      endcase
    end
  end

`ifdef CFG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [TW-1:0] tcnt_q;
  logic          abort_q;

  // A completion in the same cycle as expiry takes priority over the timeout.
  assign to_fire = pending_q && !cmd_done && (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  // Age counter of the pending command; held at zero while idle.
  always_ff @(posedge clk) begin
    if (reset) begin
      tcnt_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= to_fire;
      if (!pending_q || to_fire) tcnt_q <= '0;
      else                       tcnt_q <= tcnt_q + 1'b1;
    end
  end
  assign cmd_abort = abort_q;
`else
  assign to_fire   = 1'b0;
  assign cmd_abort = 1'b0;
`endif

  // Next-state: key sequences, bus writes, completion/timeout, IRQ sources, lock.
  always_comb begin
    logic do_lock;
    pending_d  = pending_q;
    code_d     = code_q;
    irqreq_d   = irqreq_q;
    err_d      = err_q;
    timeout_d  = timeout_q;
    cmd_irq_d  = cmd_irq_q;
    unlocked_d = unlocked_q;
    pend_d     = pend_q;
    en_d       = en_q;
    data_d     = data_q;
    ukey_d     = ukey_q;
    lkey_d     = lkey_q;
    do_lock    = n64_reset || n64_nmi;

    if (wr) begin
      if (idx == R_KEY) begin
        if (unlocked_q) begin
          if (bus_wdata == LOCK_KEY) begin
            if (lkey_q) do_lock = 1'b1;
            else        lkey_d  = 1'b1;
          end else begin
            lkey_d = 1'b0;
          end
        end else if (bus_wdata == unlock_key(ukey_q)) begin
          if (ukey_q == 2'd3) begin
            unlocked_d = 1'b1;
            ukey_d     = 2'd0;
          end else begin
            ukey_d = ukey_q + 2'd1;
          end
        end else begin
          ukey_d = 2'd0;
        end
      end else if (unlocked_q) begin
        case (idx)
          R_COMMAND: begin
            if (!pending_q) begin
              pending_d = 1'b1;
              code_d    = bus_wdata[7:0];
              irqreq_d  = bus_wdata[8];
              err_d     = 1'b0;
              timeout_d = 1'b0;
            end
          end
          R_PEND: begin
            pend_d = pend_q & ~bus_wdata[IRQ_SOURCES-1:0];
            if (bus_wdata[15]) cmd_irq_d = 1'b0;
          end
          R_EN: en_d = bus_wdata[IRQ_SOURCES-1:0];
          default: begin
            if (dsel && !pending_q) begin
              for (int k = 0; k < DATA_WORDS; k++) begin
                if (doff[3:1] == 3'(k)) begin
                  if (doff[0]) data_d[k][15:0]  = bus_wdata;
                  else         data_d[k][31:16] = bus_wdata;
                end
              end
            end
          end
        endcase
      end
    end

    if (pending_q && cmd_done) begin
      pending_d = 1'b0;
      data_d    = cmd_result;
      err_d     = cmd_error;
      cmd_irq_d = irqreq_q;
    end else if (to_fire) begin
      pending_d = 1'b0;
      err_d     = 1'b1;
      timeout_d = 1'b1;
      cmd_irq_d = irqreq_q;
    end

    // New events are applied after write-1-to-clear so a coincident set survives.
    if (unlocked_q) pend_d = pend_d | irq_src;

    // Lock leaves any in-flight command running.
    if (do_lock) begin
      unlocked_d = 1'b0;
      irqreq_d   = 1'b0;
      cmd_irq_d  = 1'b0;
      pend_d     = '0;
      en_d       = '0;
      ukey_d     = 2'd0;
      lkey_d     = 1'b0;
    end
  end

  // State registers with synchronous reset; irq is a registered OR of sources.
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q  <= 1'b0;
      code_q     <= '0;
      irqreq_q   <= 1'b0;
      err_q      <= 1'b0;
      timeout_q  <= 1'b0;
      cmd_irq_q  <= 1'b0;
      unlocked_q <= 1'b0;
      pend_q     <= '0;
      en_q       <= '0;
      data_q     <= '0;
      ukey_q     <= 2'd0;
      lkey_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      pending_q  <= pending_d;
      code_q     <= code_d;
      irqreq_q   <= irqreq_d;
      err_q      <= err_d;
      timeout_q  <= timeout_d;
      cmd_irq_q  <= cmd_irq_d;
      unlocked_q <= unlocked_d;
      pend_q     <= pend_d;
      en_q       <= en_d;
      data_q     <= data_d;
      ukey_q     <= ukey_d;
      lkey_q     <= lkey_d;
      irq_q      <= cmd_irq_q | (|(pend_q & en_q));
    end
  end

  assign cmd_pending = pending_q;
  assign cmd_code    = code_q;
  assign cmd_args    = data_q;
  assign unlocked    = unlocked_q;
  assign irq         = irq_q;
endmodule

// File: tb/tb_n64_cfg_mbox.sv
// Bench for n64_cfg_mbox: register-op vector table, hand sequences for the
// multi-cycle corners, then random traffic against a behavioural model.
module tb_n64_cfg_mbox;
  localparam int DW = 2;
  localparam int NS = 4;
  localparam int TO = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              bus_write = 1'b0;
  logic [16:0]       bus_address = '0;
  logic [15:0]       bus_wdata = '0;
  logic [15:0]       bus_rdata;
  logic              n64_reset = 1'b0;
  logic              n64_nmi = 1'b0;
  logic              cmd_pending;
  logic [7:0]        cmd_code;
  logic [32*DW-1:0]  cmd_args;
  logic              cmd_done = 1'b0;
  logic              cmd_error = 1'b0;
  logic [32*DW-1:0]  cmd_result = '0;
  logic              cmd_abort;
  logic [NS-1:0]     irq_src = '0;
  logic              unlocked;
  logic              irq;

  n64_cfg_mbox #(.DATA_WORDS(DW), .IRQ_SOURCES(NS), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .bus_write(bus_write), .bus_address(bus_address),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .n64_reset(n64_reset),
    .n64_nmi(n64_nmi), .cmd_pending(cmd_pending), .cmd_code(cmd_code),
    .cmd_args(cmd_args), .cmd_done(cmd_done), .cmd_error(cmd_error),
    .cmd_result(cmd_result), .cmd_abort(cmd_abort), .irq_src(irq_src),
    .unlocked(unlocked), .irq(irq));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [16:0] reg_addr(input logic [4:0] i);
    return {1'b1, 10'd0, i, 1'b0};
  endfunction

  task automatic bus_wr(input logic [4:0] i, input logic [15:0] d);
    bus_address = reg_addr(i); bus_wdata = d; bus_write = 1'b1;
    tick();
    bus_write = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [4:0] i, input logic [15:0] e);
    bus_address = reg_addr(i); #1;
    check(nm, 128'(bus_rdata), 128'(e));
  endtask

  task automatic unlock_seq();
    bus_wr(5'd2, 16'h5F55); bus_wr(5'd2, 16'h4E4C);
    bus_wr(5'd2, 16'h4F43); bus_wr(5'd2, 16'h4B5F);
  endtask

  function automatic logic [15:0] key_at(input int i);
    case (i)
      0: return 16'h5F55;
      1: return 16'h4E4C;
      2: return 16'h4F43;
      default: return 16'h4B5F;
    endcase
  endfunction

  // ---------------- behavioural model ----------------
  logic              m_pend, m_irqreq, m_err, m_to, m_cirq, m_unl, m_irq, m_abort;
  logic [7:0]        m_code;
  logic [NS-1:0]     m_ipend, m_ien;
  logic [DW-1:0][31:0] m_data;
  int                m_keys_ok, m_ff_run, m_start;

  task automatic model_reset();
    m_pend = 0; m_irqreq = 0; m_err = 0; m_to = 0; m_cirq = 0; m_unl = 0;
    m_irq = 0; m_abort = 0; m_code = '0; m_ipend = '0; m_ien = '0; m_data = '0;
    m_keys_ok = 0; m_ff_run = 0; m_start = 0;
  endtask

  function automatic logic [15:0] mread(input logic [16:0] a);
    int r;
    if (!(a[16] && a[15:6] == 10'd0)) return 16'h0;
    r = int'(a[5:1]);
    if (r == 0) return {m_pend, m_err, m_cirq, m_to, m_unl, 11'd0};
    if (r == 1) return {7'd0, m_irqreq, m_code};
    if (r == 3) return 16'(m_ipend);
    if (r == 4) return 16'(m_ien);
    if (r >= 8 && r < 8 + 2*DW)
      return (r % 2 == 0) ? m_data[(r-8)/2][31:16] : m_data[(r-8)/2][15:0];
    return 16'h0;
  endfunction

  // One clock of behaviour, given this cycle's inputs and cycle number.
  task automatic model_cycle(input bit w, input logic [16:0] a, input logic [15:0] d,
                             input bit done, input bit derr, input logic [32*DW-1:0] res,
                             input logic [NS-1:0] src, input bit nrst, input int cyc);
    bit was_pend, was_unl, fire, lock_now, sel, new_irq;
    int r;
    was_pend = m_pend;
    was_unl  = m_unl;
    new_irq  = m_cirq || ((m_ipend & m_ien) != '0);
    sel      = a[16] && (a[15:6] == 10'd0);
    r        = int'(a[5:1]);
    lock_now = nrst;
    fire     = 1'b0;
`ifdef CFG_TIMEOUT_EN
    fire = was_pend && !done && (cyc - m_start == TO);
`endif
    if (w && sel) begin
      if (r == 2) begin
        if (was_unl) begin
          if (d == 16'hFFFF) begin
            m_ff_run++;
            if (m_ff_run == 2) lock_now = 1'b1;
          end else m_ff_run = 0;
        end else begin
          if (d == key_at(m_keys_ok)) m_keys_ok++;
          else m_keys_ok = 0;
          if (m_keys_ok == 4) begin m_unl = 1'b1; m_keys_ok = 0; end
        end
      end else if (was_unl) begin
        if (r == 1 && !was_pend) begin
          m_pend = 1'b1; m_code = d[7:0]; m_irqreq = d[8];
          m_err = 1'b0; m_to = 1'b0; m_start = cyc;
        end else if (r == 3) begin
          m_ipend = m_ipend & ~d[NS-1:0];
          if (d[15]) m_cirq = 1'b0;
        end else if (r == 4) begin
          m_ien = d[NS-1:0];
        end else if (r >= 8 && r < 8 + 2*DW && !was_pend) begin
          if (r % 2 == 0) m_data[(r-8)/2][31:16] = d;
          else            m_data[(r-8)/2][15:0]  = d;
        end
      end
    end
    if (done && was_pend) begin
      m_pend = 1'b0; m_data = res; m_err = derr; m_cirq = m_irqreq;
    end else if (fire) begin
      m_pend = 1'b0; m_err = 1'b1; m_to = 1'b1; m_cirq = m_irqreq;
    end
    if (was_unl) m_ipend = m_ipend | src;
    if (lock_now) begin
      m_unl = 1'b0; m_irqreq = 1'b0; m_cirq = 1'b0; m_ipend = '0; m_ien = '0;
      m_keys_ok = 0; m_ff_run = 0;
    end
    m_irq   = new_irq;
    m_abort = fire;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit          wr;
    logic [4:0]  idx;
    logic [15:0] data;   // write data, or expected read data
  } vec_t;

  vec_t tbl[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    tbl.push_back('{0, 5'd0,  16'h0000});
    tbl.push_back('{1, 5'd1,  16'h1234});  // locked: ignored
    tbl.push_back('{0, 5'd0,  16'h0000});
    tbl.push_back('{0, 5'd1,  16'h0000});
    tbl.push_back('{1, 5'd2,  16'h5F55});
    tbl.push_back('{1, 5'd2,  16'h4E4C});
    tbl.push_back('{1, 5'd2,  16'h4F43});
    tbl.push_back('{0, 5'd0,  16'h0000});  // three keys: still locked
    tbl.push_back('{1, 5'd2,  16'h4B5F});
    tbl.push_back('{0, 5'd0,  16'h0800});
    tbl.push_back('{1, 5'd8,  16'hDEAD});
    tbl.push_back('{1, 5'd9,  16'hBEEF});
    tbl.push_back('{0, 5'd8,  16'hDEAD});
    tbl.push_back('{0, 5'd9,  16'hBEEF});
    tbl.push_back('{1, 5'd4,  16'hFFF2});  // only IRQ_SOURCES bits stored
    tbl.push_back('{0, 5'd4,  16'h0002});
    tbl.push_back('{0, 5'd31, 16'h0000});
    tbl.push_back('{0, 5'd12, 16'h0000});  // beyond DATA_WORDS
    tbl.push_back('{0, 5'd5,  16'h0000});
    tbl.push_back('{1, 5'd1,  16'h0142});
    tbl.push_back('{0, 5'd1,  16'h0142});
    tbl.push_back('{0, 5'd0,  16'h8800});
    tbl.push_back('{1, 5'd9,  16'h1111});  // pending: data write ignored
    tbl.push_back('{0, 5'd9,  16'hBEEF});
    tbl.push_back('{1, 5'd1,  16'h0077});  // pending: command ignored
    tbl.push_back('{0, 5'd1,  16'h0142});

    tick(); tick();
    reset = 1'b0;
    #1;
    check("reset_outs", {cmd_pending, cmd_code, cmd_args, unlocked, irq, cmd_abort}, '0);

    foreach (tbl[i]) begin
      if (tbl[i].wr) bus_wr(tbl[i].idx, tbl[i].data);
      else           rd_chk($sformatf("vec%0d", i), tbl[i].idx, tbl[i].data);
    end
    bus_address = 17'h0_0002; #1;
    check("unselected_read", 128'(bus_rdata), 128'h0);
    check("args0", 128'(cmd_args[31:0]), 128'hDEADBEEF);
    check("code", {cmd_pending, cmd_code}, {1'b1, 8'h42});

    // Completion with error and irq request.
    cmd_result = 64'h1357_2468_CAFE_F00D; cmd_error = 1'b1; cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0; cmd_error = 1'b0;
    check("irq_lat0", 128'(irq), 128'h0);
    rd_chk("res_h", 5'd8, 16'hCAFE);
    rd_chk("res_l", 5'd9, 16'hF00D);
    rd_chk("res1_h", 5'd10, 16'h1357);
    rd_chk("status_done", 5'd0, 16'h6800);
    tick();
    check("irq_lat1", 128'(irq), 128'h1);
    bus_wr(5'd3, 16'h8000);
    tick();
    check("cmd_irq_clr", 128'(irq), 128'h0);

    // Sticky source, set-wins on coincident clear.
    irq_src = 4'b0010; tick(); irq_src = '0;
    tick();
    check("src_irq", 128'(irq), 128'h1);
    rd_chk("pend_set", 5'd3, 16'h0002);
    irq_src = 4'b0010; bus_wr(5'd3, 16'h0002); irq_src = '0;
    rd_chk("pend_setwins", 5'd3, 16'h0002);
    bus_wr(5'd3, 16'h0002);
    rd_chk("pend_clr", 5'd3, 16'h0000);
    tick();
    check("irq_clr", 128'(irq), 128'h0);
    irq_src = 4'b0010; tick(); irq_src = '0; tick();

    // Lock: count restarts on non-FFFF, then two in a row lock.
    bus_wr(5'd2, 16'hFFFF); bus_wr(5'd2, 16'h1234); bus_wr(5'd2, 16'hFFFF);
    check("lock_restart", 128'(unlocked), 128'h1);
    bus_wr(5'd2, 16'hFFFF);
    check("locked", 128'(unlocked), 128'h0);
    rd_chk("lock_pend", 5'd3, 16'h0000);
    rd_chk("lock_en", 5'd4, 16'h0000);
    tick();
    check("lock_irq", 128'(irq), 128'h0);
    irq_src = 4'b0010; tick(); irq_src = '0;
    rd_chk("locked_src", 5'd3, 16'h0000);

    // Wrong key restarts; n64_reset clears partial progress.
    bus_wr(5'd2, 16'h5F55); bus_wr(5'd2, 16'h4E4C); bus_wr(5'd2, 16'h1234);
    bus_wr(5'd2, 16'h4F43); bus_wr(5'd2, 16'h4B5F);
    check("wrong_key", 128'(unlocked), 128'h0);
    bus_wr(5'd2, 16'h5F55); bus_wr(5'd2, 16'h4E4C);
    n64_reset = 1'b1; tick(); n64_reset = 1'b0;
    bus_wr(5'd2, 16'h4F43); bus_wr(5'd2, 16'h4B5F);
    check("n64rst_key", 128'(unlocked), 128'h0);

    // NMI mid-command locks but keeps the command.
    unlock_seq();
    bus_wr(5'd1, 16'h0005);
    n64_nmi = 1'b1; tick(); n64_nmi = 1'b0;
    check("nmi", {unlocked, cmd_pending, cmd_code}, {1'b0, 1'b1, 8'h05});
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
    check("nmi_done", 128'(cmd_pending), 128'h0);

    unlock_seq();
    bus_wr(5'd1, 16'h0001);
`ifdef CFG_TIMEOUT_EN
    seen = 1'b0;
    for (int i = 1; i < TO; i++) begin
      tick();
      if (!cmd_pending || cmd_abort) seen = 1'b1;
    end
    check("to_hold", 128'(seen), 128'h0);
    tick();
    check("to_abort", {cmd_pending, cmd_abort}, {1'b0, 1'b1});
    rd_chk("to_status", 5'd0, 16'h5800);
    tick();
    check("to_pulse", 128'(cmd_abort), 128'h0);
`else
    seen = 1'b0;
    for (int i = 0; i < TO + 4; i++) begin
      tick();
      if (cmd_abort) seen = 1'b1;
    end
    check("no_abort", {seen, cmd_pending}, {1'b0, 1'b1});
    rd_chk("no_to_status", 5'd0, 16'h8800);
    cmd_done = 1'b1; tick(); cmd_done = 1'b0;
`endif

    // ---------------- random phase ----------------
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [4:0] ri;
      int p;
      bit w, nr;
      p = int'($urandom_range(0, 13));
      case (p)
        0: ri = 5'd0;  1, 2: ri = 5'd1;  3, 4, 5: ri = 5'd2;  6: ri = 5'd3;
        7: ri = 5'd4;  8: ri = 5'd8;  9: ri = 5'd9;  10: ri = 5'd10;
        11: ri = 5'd11; 12: ri = 5'd12; default: ri = 5'd31;
      endcase
      w = ($urandom_range(0, 1) == 1);
      bus_address = reg_addr(ri);
      if ($urandom_range(0, 19) == 0) bus_address[16] = 1'b0;
      else if ($urandom_range(0, 19) == 0) bus_address[9] = 1'b1;
      bus_wdata = 16'($urandom);
      if (ri == 5'd2) begin
        if (m_unl) begin
          if ($urandom_range(0, 3) == 0) bus_wdata = 16'hFFFF;
        end else if ($urandom_range(0, 9) < 7) bus_wdata = key_at(m_keys_ok);
      end
      bus_write  = w;
      cmd_done   = ($urandom_range(0, 5) == 0);
      cmd_error  = 1'($urandom);
      cmd_result = {$urandom, $urandom};
      irq_src    = NS'($urandom) & NS'($urandom);
      n64_nmi    = ($urandom_range(0, 59) == 0);
      n64_reset  = ($urandom_range(0, 79) == 0);
      nr         = n64_nmi || n64_reset;
      #1;
      check("rnd_rdata", 128'(bus_rdata), 128'(mread(bus_address)));
      model_cycle(w, bus_address, bus_wdata, cmd_done, cmd_error, cmd_result, irq_src, nr, c);
      tick();
      check("rnd_outs", {cmd_pending, cmd_code, cmd_args, unlocked, irq, cmd_abort},
            {m_pend, m_code, m_data, m_unl, m_irq, m_abort});
    end
    bus_write = 1'b0; cmd_done = 1'b0; n64_nmi = 1'b0; n64_reset = 1'b0; irq_src = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
